// File: rtl/pov_pkg.sv
// Shared constants, state encoding and frame packing for the POV SPI link.
package pov_pkg;

  localparam int unsigned POS_W          = 15;
  localparam int unsigned VEC_W          = 11;
  localparam int unsigned FRAC_BITS      = 9;
  localparam int unsigned POV_FRAME_BITS = 2 * POS_W + 4 * VEC_W;

  localparam logic [POS_W-1:0] DEF_PLAYER_X = 15'h1B00;
  localparam logic [POS_W-1:0] DEF_PLAYER_Y = 15'h1780;
  localparam logic [VEC_W-1:0] DEF_FACING_X = 11'h600;
  localparam logic [VEC_W-1:0] DEF_FACING_Y = 11'h000;
  localparam logic [VEC_W-1:0] DEF_VPLANE_X = 11'h000;
  localparam logic [VEC_W-1:0] DEF_VPLANE_Y = 11'h700;

  typedef enum logic [2:0] {
    StIdle,
    StLead,
    StShift,
    StTrail,
    StGap,
    StSkip
  } tx_state_e;

  function automatic logic [POV_FRAME_BITS-1:0] pack_frame(
    input logic [POS_W-1:0] px,
    input logic [POS_W-1:0] py,
    input logic [VEC_W-1:0] fx,
    input logic [VEC_W-1:0] fy,
    input logic [VEC_W-1:0] vx,
    input logic [VEC_W-1:0] vy
  );
    return {px, py, fx, fy, vx, vy};
  endfunction

endpackage

// File: rtl/spi_phase_div.sv
// SCLK phase timer: reloading down-counter that ticks phase_end_o on its last cycle.
module spi_phase_div #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic restart_i,
  output logic phase_end_o
);

  localparam logic [7:0] Reload = 8'(CLK_DIV - 1);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - 8'd1;
    if (restart_i || (cnt_q == 8'd0)) begin
      cnt_d = Reload;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign phase_end_o = (cnt_q == 8'd0);

endmodule

// File: rtl/pov_spi_tx.sv
// SPI mode-0 master sending one 74-bit POV frame MSB first.
// Optional POV_TX_SKIP_UNCHANGED_EN suppresses traffic when the frame repeats.
module pov_spi_tx
  import pov_pkg::*;
#(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [POS_W-1:0] playerX,
  input  logic [POS_W-1:0] playerY,
  input  logic [VEC_W-1:0] facingX,
  input  logic [VEC_W-1:0] facingY,
  input  logic [VEC_W-1:0] vplaneX,
  input  logic [VEC_W-1:0] vplaneY,
  output logic             o_sclk,
  output logic             o_ss_n,
  output logic             o_mosi,
  output logic             busy,
  output logic             done
);

  localparam logic [6:0] LastBit = 7'(POV_FRAME_BITS - 1);

  tx_state_e                 state_q;
  logic [POV_FRAME_BITS-1:0] sr_q;
  logic [6:0]                bit_cnt_q;
  logic                      sclk_q, ss_n_q, mosi_q, busy_q, done_q;

  logic [POV_FRAME_BITS-1:0] frame;
  logic                      phase_end;
  logic                      skip_hit;

  assign frame = pack_frame(playerX, playerY, facingX, facingY, vplaneX, vplaneY);

  spi_phase_div #(
    .CLK_DIV (CLK_DIV)
  ) u_div (
    .clk         (clk),
    .reset_n     (reset_n),
    .restart_i   (state_q == StIdle),
    .phase_end_o (phase_end)
  );

`ifdef POV_TX_SKIP_UNCHANGED_EN
  logic [POV_FRAME_BITS-1:0] copy_q;
  logic                      copy_vld_q;

  assign skip_hit = copy_vld_q && (frame == copy_q);

  // Copy becomes valid only once the frame has fully left the wire.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      copy_q     <= '0;
      copy_vld_q <= 1'b0;
    end else if ((state_q == StIdle) && start && !skip_hit) begin
      copy_q     <= frame;
      copy_vld_q <= 1'b0;
    end else if ((state_q == StGap) && phase_end) begin
      copy_vld_q <= 1'b1;
    end
  end
`else
  assign skip_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      sr_q      <= '0;
      bit_cnt_q <= '0;
      sclk_q    <= 1'b0;
      ss_n_q    <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            busy_q <= 1'b1;
            if (skip_hit) begin
              state_q <= StSkip;
            end else begin
              state_q   <= StLead;
              sr_q      <= frame;
              bit_cnt_q <= '0;
              sclk_q    <= 1'b0;
              ss_n_q    <= 1'b0;
              mosi_q    <= frame[POV_FRAME_BITS-1];
            end
          end
        end
        StLead: begin
          if (phase_end) begin
            state_q <= StShift;
            sclk_q  <= 1'b1;
          end
        end
        StShift: begin
          if (phase_end) begin
            if (sclk_q) begin
              // Falling edge: advance data so it is settled long before the next rise.
              sclk_q <= 1'b0;
              sr_q   <= sr_q << 1;
              mosi_q <= sr_q[POV_FRAME_BITS-2];
            end else if (bit_cnt_q == LastBit) begin
              state_q <= StTrail;
            end else begin
              bit_cnt_q <= bit_cnt_q + 7'd1;
              sclk_q    <= 1'b1;
            end
          end
        end
        StTrail: begin
          if (phase_end) begin
            state_q <= StGap;
            ss_n_q  <= 1'b1;
          end
        end
        StGap: begin
          if (phase_end) begin
            state_q <= StIdle;
            mosi_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        StSkip: begin
          state_q <= StIdle;
          busy_q  <= 1'b0;
          done_q  <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign o_sclk = sclk_q;
  assign o_ss_n = ss_n_q;
  assign o_mosi = mosi_q;
  assign busy   = busy_q;
  assign done   = done_q;

endmodule

// File: tb/tb_pov_spi_tx.sv
// Directed bench for pov_spi_tx at CLK_DIV=4; define POV_TX_SKIP_UNCHANGED_EN to cover skipping.
module tb_pov_spi_tx;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        start = 1'b0;
  logic [14:0] player_x = '0, player_y = '0;
  logic [10:0] facing_x = '0, facing_y = '0, vplane_x = '0, vplane_y = '0;
  logic        o_sclk, o_ss_n, o_mosi, busy, done;

  int checks = 0;
  int errors = 0;

  pov_spi_tx #(
    .CLK_DIV (4)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .playerX (player_x),
    .playerY (player_y),
    .facingX (facing_x),
    .facingY (facing_y),
    .vplaneX (vplane_x),
    .vplaneY (vplane_y),
    .o_sclk  (o_sclk),
    .o_ss_n  (o_ss_n),
    .o_mosi  (o_mosi),
    .busy    (busy),
    .done    (done)
  );

  always #5 clk = ~clk;

  // Receiver model: count SCLK rises and collect MOSI at each rise (pre-edge values).
  int          rises = 0;
  logic        prev_sclk = 1'b0;
  logic [73:0] bits = '0;
  always @(posedge clk) begin
    if (o_sclk && !prev_sclk) begin
      rises = rises + 1;
      bits  = {bits[72:0], o_mosi};
    end
    prev_sclk = o_sclk;
  end

  localparam logic [73:0] FRAME_A = {15'h1B00, 15'h1780, 11'h600, 11'h000, 11'h000, 11'h700};
  localparam logic [73:0] FRAME_B = {15'h2A55, 15'h0123, 11'h7FF, 11'h001, 11'h2AA, 11'h555};
  localparam logic [73:0] FRAME_C = {15'h7FFF, 15'h0000, 11'h400, 11'h3FF, 11'h123, 11'h456};

  task automatic set_frame(input logic [73:0] f);
    {player_x, player_y, facing_x, facing_y, vplane_x, vplane_y} = f;
  endtask

  // Call just after a negedge with start already high; negedge k samples cycle k.
  task automatic wait_frame(input bit hold, input int poke_k, output int lat,
                            output int first_rise, output int ss_low, output int hi_run,
                            output int busy_lo);
    lat = -1; first_rise = 0; ss_low = 0; hi_run = 0; busy_lo = 0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      if (k == 1 && !hold) start = 1'b0;
      if (k == poke_k) begin
        start = 1'b1;
        set_frame(FRAME_C ^ 74'h3_FFFF_0000_FFFF_0000);
      end
      if (k == poke_k + 1) start = 1'b0;
      if (!o_ss_n && ss_low == 0) ss_low = k;
      if (o_sclk && first_rise == 0) first_rise = k;
      if (done) begin
        lat = k;
        break;
      end
      if (o_ss_n && ss_low != 0) hi_run++;
      if (!busy) busy_lo++;
    end
  endtask

  task automatic test_reset;
    int r0;
    bit ss_bad;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (o_sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk got %b want 0", o_sclk); end
    checks++; if (o_ss_n !== 1'b1) begin errors++; $display("FAIL reset_ss_n got %b want 1", o_ss_n); end
    checks++; if (o_mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi got %b want 0", o_mosi); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", done); end
    reset_n = 1'b1;
    r0 = rises;
    ss_bad = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (o_ss_n !== 1'b1 || busy !== 1'b0) ss_bad = 1'b1;
    end
    checks++; if (rises - r0 != 0) begin errors++; $display("FAIL idle_rises got %0d want 0", rises - r0); end
    checks++; if (ss_bad) begin errors++; $display("FAIL idle_ss_busy got %b want 0", ss_bad); end
  endtask

  task automatic test_single_frame;
    int r0, lat, fr, sl, hr, bl;
    set_frame(FRAME_A);
    start = 1'b1;
    r0 = rises;
    wait_frame(1'b0, -5, lat, fr, sl, hr, bl);
    checks++; if (lat != 605) begin errors++; $display("FAIL single_latency got %0d want 605", lat); end
    checks++; if (sl != 1) begin errors++; $display("FAIL single_ss_fall got %0d want 1", sl); end
    checks++; if (fr != 5) begin errors++; $display("FAIL single_first_rise got %0d want 5", fr); end
    checks++; if (rises - r0 != 74) begin errors++; $display("FAIL single_rises got %0d want 74", rises - r0); end
    checks++; if (bits !== FRAME_A) begin errors++; $display("FAIL single_bits got %h want %h", bits, FRAME_A); end
    // 13.5 in UQ6.9, -1.0 and -0.5 in SQ2.9
    checks++; if (bits[73:59] !== 15'h1B00 || bits[43:33] !== 11'h600 || bits[10:0] !== 11'h700) begin
      errors++; $display("FAIL single_fields got %h/%h/%h want 1b00/600/700", bits[73:59], bits[43:33], bits[10:0]);
    end
    checks++; if (hr != 4) begin errors++; $display("FAIL single_gap got %0d want 4", hr); end
    checks++; if (bl != 0) begin errors++; $display("FAIL single_busy_low got %0d want 0", bl); end
  endtask

  task automatic test_back_to_back;
    int r0, lat, fr, sl, hr, bl;
    set_frame(FRAME_A);
    start = 1'b1;
    r0 = rises;
    wait_frame(1'b1, -5, lat, fr, sl, hr, bl);
    checks++; if (lat != 605) begin errors++; $display("FAIL b2b_lat1 got %0d want 605", lat); end
    checks++; if (bits !== FRAME_A) begin errors++; $display("FAIL b2b_bits1 got %h want %h", bits, FRAME_A); end
    checks++; if (hr != 4) begin errors++; $display("FAIL b2b_gap got %0d want 4", hr); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b2b_busy_at_done got %b want 0", busy); end
    set_frame(FRAME_B);
    r0 = rises;
    wait_frame(1'b0, -5, lat, fr, sl, hr, bl);
    checks++; if (sl != 1) begin errors++; $display("FAIL b2b_accept got %0d want 1", sl); end
    checks++; if (lat != 605) begin errors++; $display("FAIL b2b_lat2 got %0d want 605", lat); end
    checks++; if (rises - r0 != 74) begin errors++; $display("FAIL b2b_rises2 got %0d want 74", rises - r0); end
    checks++; if (bits !== FRAME_B) begin errors++; $display("FAIL b2b_bits2 got %h want %h", bits, FRAME_B); end
  endtask

  task automatic test_busy_ignore;
    int r0, lat, fr, sl, hr, bl;
    bit ss_bad;
    set_frame(FRAME_C);
    start = 1'b1;
    r0 = rises;
    wait_frame(1'b0, 200, lat, fr, sl, hr, bl);
    checks++; if (lat != 605) begin errors++; $display("FAIL ignore_latency got %0d want 605", lat); end
    checks++; if (bits !== FRAME_C) begin errors++; $display("FAIL ignore_bits got %h want %h", bits, FRAME_C); end
    ss_bad = 1'b0;
    repeat (50) begin
      @(negedge clk);
      if (o_ss_n !== 1'b1 || busy !== 1'b0) ss_bad = 1'b1;
    end
    checks++; if (rises - r0 != 74) begin errors++; $display("FAIL ignore_rises got %0d want 74", rises - r0); end
    checks++; if (ss_bad) begin errors++; $display("FAIL ignore_second_frame got %b want 0", ss_bad); end
  endtask

  task automatic test_reset_abort;
    int r0, lat, fr, sl, hr, bl;
    bit reached;
    set_frame(FRAME_A);
    start = 1'b1;
    r0 = rises;
    reached = 1'b0;
    for (int k = 1; k <= 2000; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (rises - r0 >= 40) begin
        reached = 1'b1;
        break;
      end
    end
    checks++; if (!reached) begin errors++; $display("FAIL abort_reach40 got %0d want 40", rises - r0); end
    #1 reset_n = 1'b0;
    #1;
    checks++; if (o_ss_n !== 1'b1 || o_sclk !== 1'b0 || o_mosi !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL abort_outputs got ss_n=%b sclk=%b mosi=%b busy=%b want 1/0/0/0",
                         o_ss_n, o_sclk, o_mosi, busy);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    set_frame(FRAME_B);
    start = 1'b1;
    r0 = rises;
    wait_frame(1'b0, -5, lat, fr, sl, hr, bl);
    checks++; if (lat != 605) begin errors++; $display("FAIL abort_fresh_lat got %0d want 605", lat); end
    checks++; if (rises - r0 != 74) begin errors++; $display("FAIL abort_fresh_rises got %0d want 74", rises - r0); end
    checks++; if (bits !== FRAME_B) begin errors++; $display("FAIL abort_fresh_bits got %h want %h", bits, FRAME_B); end
  endtask

  task automatic test_repeat_frame;
    int r0, lat, fr, sl, hr, bl;
    set_frame(FRAME_A);
    start = 1'b1;
    wait_frame(1'b0, -5, lat, fr, sl, hr, bl);
    @(negedge clk);
    start = 1'b1;
    r0 = rises;
    wait_frame(1'b0, -5, lat, fr, sl, hr, bl);
`ifdef POV_TX_SKIP_UNCHANGED_EN
    checks++; if (lat != 2) begin errors++; $display("FAIL skip_latency got %0d want 2", lat); end
    checks++; if (rises - r0 != 0) begin errors++; $display("FAIL skip_rises got %0d want 0", rises - r0); end
    checks++; if (sl != 0) begin errors++; $display("FAIL skip_ss got %0d want 0", sl); end
`else
    checks++; if (lat != 605) begin errors++; $display("FAIL repeat_latency got %0d want 605", lat); end
    checks++; if (rises - r0 != 74) begin errors++; $display("FAIL repeat_rises got %0d want 74", rises - r0); end
`endif
    @(negedge clk);
    set_frame(FRAME_B);
    start = 1'b1;
    r0 = rises;
    wait_frame(1'b0, -5, lat, fr, sl, hr, bl);
    checks++; if (lat != 605) begin errors++; $display("FAIL new_frame_latency got %0d want 605", lat); end
    checks++; if (rises - r0 != 74) begin errors++; $display("FAIL new_frame_rises got %0d want 74", rises - r0); end
    checks++; if (bits !== FRAME_B) begin errors++; $display("FAIL new_frame_bits got %h want %h", bits, FRAME_B); end
  endtask

  initial begin
    test_reset();
    @(negedge clk);
    test_single_frame();
    @(negedge clk);
    test_back_to_back();
    @(negedge clk);
    test_busy_ignore();
    test_reset_abort();
    @(negedge clk);
    test_repeat_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
